// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller: FSM state encoding and ALU command width.
package alu_pkg;

    localparam int ALU_CMD_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester/response bus of the shared-ALU controller; master drives requests, slave is the controller.
interface alu_share_ctrl_if
    import alu_pkg::*;
#(
    parameter int N       = 6,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) ();

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*N-1:0]         req_a;
    logic [NUM_REQ*N-1:0]         req_b;
    logic [NUM_REQ*ALU_CMD_W-1:0] req_cmd;
    logic                         resp_valid;
    logic                         resp_ready;
    logic [N-1:0]                 resp_z;
    logic [ID_W-1:0]              resp_id;
    logic [15:0]                  ops_done;

    modport master (
        output req_valid, req_a, req_b, req_cmd, resp_ready,
        input  req_ready, resp_valid, resp_z, resp_id, ops_done
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cmd, resp_ready,
        output req_ready, resp_valid, resp_z, resp_id, ops_done
    );

endinterface

// File: rtl/alu_share_ctrl_alu.sv
// K_ALU: the lab's combinational ALU; codes 12..15 are unassigned and yield zero.
module K_ALU
    import alu_pkg::*;
#(
    parameter int N = 6
) (
    input  logic [N-1:0]         A,
    input  logic [N-1:0]         B,
    input  logic [ALU_CMD_W-1:0] CMD,
    output logic [N-1:0]         Z
);

    always_comb begin
        Z = '0;
        case (CMD)
            4'd0:    Z = A + B;
            4'd1:    Z = A - B;
            4'd2:    Z = A & B;
            4'd3:    Z = A | B;
            4'd4:    Z = A ^ B;
            4'd5:    Z = ~A;
            4'd6:    Z = {A[N-2:0], 1'b0};
            4'd7:    Z = {1'b0, A[N-1:1]};
            4'd8:    Z = A * B;
            4'd9:    Z = (A > B) ? A : B;
            4'd10:   Z = (A < B) ? A : B;
            4'd11:   Z = B;
            default: Z = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one K_ALU among NUM_REQ requesters; one operation in flight,
// result returned on a single response channel tagged with the requester index.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int N       = 6,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_ctrl_if.slave  bus
);

    typedef logic [ID_W-1:0] id_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [N-1:0]           r_a;
    logic [N-1:0]           r_b;
    logic [ALU_CMD_W-1:0]   r_cmd;
    id_t                    r_id;
    id_t                    r_rrPtr;
    logic                   r_respValid;
    logic [N-1:0]           r_respZ;
    id_t                    r_respId;
    logic [15:0]            r_opsDone;
    logic [N-1:0]           w_aluZ;
    logic [NUM_REQ-1:0]     w_readyVec;
    id_t                    w_grant;
    logic                   w_anyValid;
    logic                   w_accept;
    logic                   w_respDone;

    // Downward scan so the lowest offset from ptr is the one left standing.
    function automatic id_t rrPick(input logic [NUM_REQ-1:0] valid, input id_t ptr);
        id_t pick;
        int  idx;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (valid[idx]) pick = id_t'(idx);
        end
        return pick;
    endfunction

    assign w_anyValid = |bus.req_valid;
    assign w_grant    = rrPick(bus.req_valid, r_rrPtr);
    assign w_accept   = (r_state == IDLE) && w_anyValid && rst_n;
    assign w_respDone = (r_state == RESP) && bus.resp_ready;

    always_comb begin
        w_readyVec = '0;
        if (w_accept) w_readyVec[w_grant] = 1'b1;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyValid) w_nextState = EXEC;
            EXEC:    w_nextState = RESP;
            RESP:    if (bus.resp_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    // The ALU sees only these registers, so requester operands may change freely after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_cmd       <= '0;
            r_id        <= '0;
            r_rrPtr     <= '0;
            r_respValid <= 1'b0;
            r_respZ     <= '0;
            r_respId    <= '0;
            r_opsDone   <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= bus.req_a[w_grant*N +: N];
                r_b   <= bus.req_b[w_grant*N +: N];
                r_cmd <= bus.req_cmd[w_grant*ALU_CMD_W +: ALU_CMD_W];
                r_id  <= w_grant;
            end
            if (r_state == EXEC) begin
                r_respZ     <= w_aluZ;
                r_respId    <= r_id;
                r_respValid <= 1'b1;
            end
            if (w_respDone) begin
                r_respValid <= 1'b0;
                r_opsDone   <= r_opsDone + 16'd1;
                r_rrPtr     <= (r_id == id_t'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
            end
        end
    end

    K_ALU #(.N(N)) u_alu (
        .A   (r_a),
        .B   (r_b),
        .CMD (r_cmd),
        .Z   (w_aluZ)
    );

    assign bus.req_ready  = w_readyVec;
    assign bus.resp_valid = r_respValid;
    assign bus.resp_z     = r_respZ;
    assign bus.resp_id    = r_respId;
    assign bus.ops_done   = r_opsDone;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: vector table, hand-written corner sequences and random traffic,
// all checked every cycle against a transaction-level model of the controller.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int N       = 6;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_share_ctrl_if #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    alu_share_ctrl #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int id;
        int a;
        int b;
        int cmd;
        int expZ;
    } vec_t;

    vec_t vecs[15];

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;

    // Model: phase 0 waits for a grant, 1 the op is in the ALU, 2 the result is offered.
    int mPhase, mPtr, mOps, mPendId, mPendZ, mLastId, mLastZ;
    int sA[NUM_REQ], sB[NUM_REQ], sCmd[NUM_REQ];
    logic [NUM_REQ-1:0] sValid;
    logic sRespReady;
    int lastGrant, sZ, sId;
    logic sawResp;
    int grantLog[$];

    function automatic int aluRef(int a, int b, int cmd);
        int r;
        case (cmd)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = ~a;
            6:  r = a * 2;
            7:  r = a / 2;
            8:  r = a * b;
            9:  r = (a > b) ? a : b;
            10: r = (a < b) ? a : b;
            11: r = b;
            default: r = 0;
        endcase
        return r & ((1 << N) - 1);
    endfunction

    function automatic int expGrant();
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sValid[(mPtr + k) % NUM_REQ]) return (mPtr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic void modelReset();
        mPhase  = 0;
        mPtr    = 0;
        mOps    = 0;
        mLastId = 0;
        mLastZ  = 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One clock: compare DUT against the model at the falling edge, advance the model at the rising edge.
    task automatic tick();
        int g;
        @(negedge clk);
        sValid     = bus.req_valid;
        sRespReady = bus.resp_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
            sA[i]   = int'(bus.req_a[i*N +: N]);
            sB[i]   = int'(bus.req_b[i*N +: N]);
            sCmd[i] = int'(bus.req_cmd[i*ALU_CMD_W +: ALU_CMD_W]);
        end
        if (!rst_n) modelReset();
        g = (mPhase == 0 && rst_n) ? expGrant() : -1;
        checkOutput("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        checkOutput("resp_valid", 32'(bus.resp_valid), 32'(mPhase == 2));
        checkOutput("resp_z", 32'(bus.resp_z), mLastZ);
        checkOutput("resp_id", 32'(bus.resp_id), mLastId);
        checkOutput("ops_done", 32'(bus.ops_done), mOps);
        lastGrant = g;
        sawResp   = bus.resp_valid;
        sZ        = int'(bus.resp_z);
        sId       = int'(bus.resp_id);
        @(posedge clk);
        if (!rst_n) begin
            modelReset();
        end else begin
            case (mPhase)
                0: if (g >= 0) begin
                       mPendId = g;
                       mPendZ  = aluRef(sA[g], sB[g], sCmd[g]);
                       mPhase  = 1;
                       grantLog.push_back(g);
                   end
                1: begin
                       mPhase  = 2;
                       mLastId = mPendId;
                       mLastZ  = mPendZ;
                   end
                default: if (sRespReady) begin
                       mPhase = 0;
                       mOps   = (mOps + 1) % 65536;
                       mPtr   = (mPendId + 1) % NUM_REQ;
                   end
            endcase
        end
        cyc++;
        #1;
    endtask

    task automatic setReq(input int id, input int a, input int b, input int cmd, input logic v);
        bus.req_a[id*N +: N]                     = N'(a);
        bus.req_b[id*N +: N]                     = N'(b);
        bus.req_cmd[id*ALU_CMD_W +: ALU_CMD_W]   = ALU_CMD_W'(cmd);
        bus.req_valid[id]                        = v;
    endtask

    task automatic applyStimulus(input vec_t v);
        setReq(v.id, v.a, v.b, v.cmd, 1'b1);
        bus.resp_ready = 1'b1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Waits for the next grant and withdraws that requester's valid after its accept edge.
    task automatic waitGrant(output int g);
        g = -1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (lastGrant >= 0) begin
                g = lastGrant;
                bus.req_valid[g] = 1'b0;
                break;
            end
        end
        checkOutput("grant_in_time", 32'(g >= 0), 32'd1);
    endtask

    task automatic waitDone();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (sawResp && sRespReady) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("resp_in_time", 32'(done), 32'd1);
    endtask

    task automatic runVector(input vec_t v);
        int acc, lat;
        applyStimulus(v);
        waitGrant(acc);
        checkOutput("vec_grant", acc, v.id);
        acc = cyc;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (sawResp) begin
                lat = cyc - acc;
                break;
            end
        end
        checkOutput("vec_latency", lat, 2);
        checkOutput("vec_z", sZ, v.expZ);
        checkOutput("vec_id", sId, v.id);
    endtask

    initial begin
        int g1, g2, n, quiet;
        int gCyc[4];

        vecs[0]  = '{0,  5,  3,  8, 15};
        vecs[1]  = '{1, 10,  7,  0, 17};
        vecs[2]  = '{2,  3,  5,  1, 62};
        vecs[3]  = '{3, 12, 10,  2,  8};
        vecs[4]  = '{0, 12,  3,  3, 15};
        vecs[5]  = '{1, 42, 15,  4, 37};
        vecs[6]  = '{2,  5,  0,  5, 58};
        vecs[7]  = '{3, 33,  0,  6,  2};
        vecs[8]  = '{0, 33,  0,  7, 16};
        vecs[9]  = '{1,  9, 20,  9, 20};
        vecs[10] = '{2,  9, 20, 10,  9};
        vecs[11] = '{3,  1, 44, 11, 44};
        vecs[12] = '{0,  7,  7, 13,  0};
        vecs[13] = '{1, 10, 10,  8, 36};
        vecs[14] = '{2, 63,  1,  0,  0};

        rst_n          = 1'b0;
        bus.req_valid  = '1;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_cmd    = '0;
        bus.resp_ready = 1'b0;
        modelReset();
        tick();
        tick();
        checkOutput("reset_ready", 32'(bus.req_ready), 32'd0);
        bus.req_valid = '0;
        rst_n         = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) runVector(vecs[i]);
        checkOutput("table_ops", 32'(bus.ops_done), 32'd15);

        $display("[TB] four-way contention");
        doReset();
        for (int i = 0; i < NUM_REQ; i++) setReq(i, 10 + i, 3 + i, i, 1'b1);
        bus.resp_ready = 1'b1;
        grantLog.delete();
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            tick();
            if (lastGrant >= 0) begin
                bus.req_valid[lastGrant] = 1'b0;
                gCyc[n] = cyc;
                n++;
            end
        end
        checkOutput("fourway_count", n, 4);
        for (int k = 0; k < 3; k++) tick();
        for (int i = 0; i < 4; i++) checkOutput("fourway_order", grantLog[i], i);
        for (int i = 1; i < 4; i++) checkOutput("fourway_gap", gCyc[i] - gCyc[i-1], 3);
        checkOutput("fourway_ops", 32'(bus.ops_done), 32'd4);

        $display("[TB] rotation fairness");
        setReq(2, 7, 2, 0, 1'b1);
        waitGrant(g1);
        waitDone();
        setReq(0, 1, 1, 0, 1'b1);
        setReq(3, 2, 2, 0, 1'b1);
        waitGrant(g1);
        waitDone();
        waitGrant(g2);
        waitDone();
        checkOutput("rotation_first", g1, 3);
        checkOutput("rotation_second", g2, 0);

        $display("[TB] backpressure");
        bus.resp_ready = 1'b0;
        setReq(1, 20, 9, 1, 1'b1);
        waitGrant(g1);
        setReq(0, 4, 4, 0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (sawResp) break;
        end
        quiet = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (lastGrant >= 0) quiet++;
        end
        checkOutput("bp_no_grant", quiet, 0);
        checkOutput("bp_z", sZ, 11);
        bus.resp_ready = 1'b1;
        tick();
        tick();
        checkOutput("bp_next_accept", lastGrant, 0);
        bus.req_valid[0] = 1'b0;
        waitDone();

        $display("[TB] operand change after accept");
        setReq(1, 5, 3, 0, 1'b1);
        waitGrant(g1);
        bus.req_a[1*N +: N] = N'(63);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (sawResp) break;
        end
        checkOutput("late_change_z", sZ, 8);

        $display("[TB] reset mid-operation");
        setReq(1, 6, 6, 2, 1'b1);
        waitGrant(g1);
        #2 rst_n = 1'b0;
        #1 checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst_ops", 32'(bus.ops_done), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        setReq(1, 3, 4, 0, 1'b1);
        setReq(2, 5, 6, 0, 1'b1);
        waitGrant(g1);
        waitDone();
        waitGrant(g2);
        waitDone();
        checkOutput("rst_first_grant", g1, 1);
        checkOutput("rst_second_grant", g2, 2);

        $display("[TB] random traffic");
        for (int k = 0; k < 800; k++) begin
            rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                setReq(i, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                       int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
